// File: rtl/requant_pkg.sv
// requant_pkg: shared widths, config register addresses and int32 limits
// for the conv1d requantisation stage.
package requant_pkg;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 8;
    localparam logic [2:0] CFG_BIAS    = 3'd0;
    localparam logic [2:0] CFG_MULT    = 3'd1;
    localparam logic [2:0] CFG_SHIFT   = 3'd2;
    localparam logic [2:0] CFG_OFFSET  = 3'd3;
    localparam logic [2:0] CFG_ACT_MIN = 3'd4;
    localparam logic [2:0] CFG_ACT_MAX = 3'd5;
    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
    localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;
endpackage

// File: rtl/requant_srdhm.sv
// requant_srdhm: registered saturating rounding doubling high multiply.
module requant_srdhm
    import requant_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] x,
    input  logic signed [ACC_W-1:0] mult,
    output logic signed [ACC_W-1:0] y
);
    localparam logic signed [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] MAX = ~MIN;
    localparam logic signed [2*ACC_W-1:0] NUDGE_POS = (2*ACC_W)'(1) <<< (ACC_W-2);
    localparam logic signed [2*ACC_W-1:0] NUDGE_NEG = (2*ACC_W)'(1) - NUDGE_POS;

    logic signed [2*ACC_W-1:0] prod, sum, quo;
    logic sat, round_up;

    always_comb begin
        sat = (x == MIN) && (mult == MIN);
        prod = (2*ACC_W)'(x) * (2*ACC_W)'(mult);
        sum = prod + (prod[2*ACC_W-1] ? NUDGE_NEG : NUDGE_POS);
        quo = sum >>> (ACC_W-1);
        // arithmetic shift floors; bump negatives with a remainder to truncate toward zero
        round_up = sum[2*ACC_W-1] && (|sum[ACC_W-2:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            y <= '0;
        else if (en)
            y <= sat ? MAX : ACC_W'(quo) + ACC_W'(round_up);
    end
endmodule

// File: rtl/requant_stage.sv
// requant_stage: 3-stage requantiser (bias+shift, SRDHM, rounding shift,
// offset, clamp) with valid/ready flow control and a busy-gated config bank.
module requant_stage
    import requant_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [ACC_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic             cfg_err
);
    logic signed [ACC_W-1:0] bias, mult, shift, offset, act_min, act_max;
    logic signed [ACC_W-1:0] bias_eff, shift_eff, x_sum, x_next, s1_x, s2_y, y_shr, y_rnd;
    logic signed [ACC_W:0]   y_off, y_clamp;
    logic [ACC_W-1:0]        e, mask, rem, thr;
    logic                    v1, v2, en, cfg_ok;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign busy     = v1 || v2 || out_valid;
    assign cfg_ok   = cfg_we && !busy;

    // a write landing on the same edge as an accept must already steer S1
    always_comb begin
        bias_eff  = (cfg_ok && cfg_addr == CFG_BIAS) ? $signed(cfg_data) : bias;
        shift_eff = (cfg_ok && cfg_addr == CFG_SHIFT) ? $signed(cfg_data) : shift;
        x_sum     = $signed(in_acc) + bias_eff;
        x_next    = (shift_eff > 0) ? (x_sum << shift_eff) : x_sum;
    end

    requant_srdhm #(.ACC_W(ACC_W)) u_srdhm (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .x    (s1_x),
        .mult (mult),
        .y    (s2_y)
    );

    always_comb begin
        e       = -shift;
        mask    = (ACC_W'(1) << e) - ACC_W'(1);
        rem     = s2_y & mask;
        thr     = (mask >> 1) + {{(ACC_W-1){1'b0}}, s2_y[ACC_W-1]};
        y_shr   = s2_y >>> e;
        y_rnd   = (shift < 0) ? y_shr + ACC_W'(rem > thr) : s2_y;
        y_off   = (ACC_W+1)'(y_rnd) + (ACC_W+1)'(offset);
        y_clamp = (y_off < (ACC_W+1)'(act_min)) ? (ACC_W+1)'(act_min) :
                  (y_off > (ACC_W+1)'(act_max)) ? (ACC_W+1)'(act_max) : y_off;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            s1_x      <= '0;
            out_data  <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            s1_x      <= x_next;
            out_data  <= OUT_W'(y_clamp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias    <= '0;
            mult    <= '0;
            shift   <= '0;
            offset  <= '0;
            act_min <= ACC_W'(-128);
            act_max <= ACC_W'(127);
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_err || (cfg_we && busy);
            if (cfg_ok) begin
                case (cfg_addr)
                    CFG_BIAS:    bias    <= cfg_data;
                    CFG_MULT:    mult    <= cfg_data;
                    CFG_SHIFT:   shift   <= cfg_data;
                    CFG_OFFSET:  offset  <= cfg_data;
                    CFG_ACT_MIN: act_min <= cfg_data;
                    CFG_ACT_MAX: act_max <= cfg_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_requant_stage.sv
// tb_requant_stage: directed self-checking bench for requant_stage.
module tb_requant_stage;
    import requant_pkg::*;

    logic        clk = 0, rst_n = 0, cfg_we = 0, in_valid = 0, out_ready = 1;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0, in_acc = '0;
    logic        in_ready, out_valid, busy, cfg_err;
    logic [7:0]  out_data;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    requant_stage #(.ACC_W(32), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_acc(in_acc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .cfg_err(cfg_err)
    );

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    // presents one sample, returns first output and edges from accept to out_valid (-1 on timeout)
    task automatic send_and_wait(input logic [31:0] acc, output logic [7:0] d, output int lat);
        in_valid = 1; in_acc = acc;
        @(posedge clk); #1;
        in_valid = 0; cfg_we = 0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        d = out_data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [7:0] d; int lat;
        cfg_write(CFG_MULT, 32'h4000_0000);
        cfg_write(CFG_SHIFT, 32'hFFFF_FFFF);
        cfg_write(CFG_OFFSET, 32'hFFFF_FFFD);
        send_and_wait(32'd100, d, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        checks++; if (d !== 8'd22) begin failures++; $display("FAIL basic_data got=%0d exp=22", $signed(d)); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got busy=%b ov=%b exp 0 0", busy, out_valid); end
    endtask

    task automatic test_negative_round;
        logic [7:0] d; int lat;
        cfg_write(CFG_OFFSET, 32'd0);
        send_and_wait(-32'sd10, d, lat);
        checks++; if (d !== 8'hFD || lat !== 3) begin failures++; $display("FAIL neg_round got=%0d lat=%0d exp=-3 lat=3", $signed(d), lat); end
    endtask

    task automatic test_saturate;
        logic [7:0] d; int lat;
        cfg_write(CFG_MULT, 32'h8000_0000);
        send_and_wait(32'h8000_0000, d, lat);
        checks++; if (d !== 8'd127) begin failures++; $display("FAIL saturate got=%0d exp=127", $signed(d)); end
    endtask

    task automatic test_clamp_low;
        logic [7:0] d; int lat;
        cfg_write(CFG_SHIFT, 32'd0);
        cfg_write(CFG_MULT, 32'h4000_0000);
        send_and_wait(-32'sd1000, d, lat);
        checks++; if (d !== 8'h80) begin failures++; $display("FAIL clamp_low got=%0d exp=-128", $signed(d)); end
    endtask

    task automatic test_bias_shift;
        logic [7:0] d; int lat;
        cfg_write(CFG_BIAS, 32'd3);
        cfg_write(CFG_SHIFT, 32'd2);
        cfg_write(CFG_MULT, 32'h7FFF_FFFF);
        send_and_wait(32'd4, d, lat);
        checks++; if (d !== 8'd28) begin failures++; $display("FAIL bias_shift got=%0d exp=28", $signed(d)); end
        cfg_write(CFG_BIAS, 32'd0);
        cfg_write(CFG_SHIFT, 32'd0);
    endtask

    task automatic test_back_to_back;
        int sent = 0, got = 0;
        logic acc_now, take_now;
        logic [7:0] dv, held = '0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            in_valid = (sent < 5); in_acc = 32'(sent + 1);
            out_ready = !(c >= 4 && c <= 6);
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready c=%0d got=%b exp=0", c, in_ready); end
            end
            if (c == 4) held = out_data;
            if (c == 6) begin
                checks++; if (out_data !== held || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_stall_hold got=%0d ov=%b exp=%0d ov=1", out_data, out_valid, held); end
            end
            acc_now = in_valid && in_ready;
            take_now = out_valid && out_ready;
            dv = out_data;
            @(posedge clk); #1;
            if (acc_now) sent++;
            if (take_now) begin
                checks++; if (dv !== 8'(got + 1)) begin failures++; $display("FAIL b2b_order got=%0d exp=%0d", dv, got + 1); end
                got++;
            end
        end
        in_valid = 0; out_ready = 1;
        checks++; if (got !== 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", got); end
    endtask

    task automatic test_cfg_busy;
        int n = 0;
        in_valid = 1; in_acc = 32'd100;
        @(posedge clk); #1;
        in_valid = 0;
        cfg_write(CFG_ACT_MAX, 32'd50);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_set got=%b exp=1", cfg_err); end
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd100) begin failures++; $display("FAIL cfg_discard got=%0d ov=%b exp=100 ov=1", out_data, out_valid); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_sticky got=%b exp=1", cfg_err); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] d; int lat;
        in_valid = 1; in_acc = 32'd9;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL async_reset got ov=%b busy=%b err=%b exp 0 0 0", out_valid, busy, cfg_err); end
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flush got ov=%b busy=%b exp 0 0", out_valid, busy); end
        cfg_write(CFG_MULT, 32'h7FFF_FFFF);
        cfg_we = 1; cfg_addr = CFG_BIAS; cfg_data = 32'd10;
        send_and_wait(32'd7, d, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
        checks++; if (d !== 8'd17) begin failures++; $display("FAIL concurrent_bias got=%0d exp=17", $signed(d)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_round();
        test_saturate();
        test_clamp_low();
        test_bias_shift();
        test_back_to_back();
        test_cfg_busy();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/requant_stage.md
REQUANT_STAGE -- requirements
Module: requant_stage

Interface
REQ-001 Parameter ACC_W, default 32, accumulator and config word width.
REQ-002 Parameter OUT_W, default 8, quantized output width.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cfg_we  input  1  config write strobe.
REQ-006 cfg_addr  input  3  config register select: 0 bias, 1 output_multiplier, 2 output_shift, 3 output_offset, 4 act_min, 5 act_max.
REQ-007 cfg_data  input  ACC_W  signed config write value.
REQ-008 in_valid  input  1  raw conv1d accumulator presented.
REQ-009 in_ready  output  1  stage accepts in_acc this cycle.
REQ-010 in_acc  input  ACC_W  signed raw accumulator from conv1d.
REQ-011 out_valid  output  1  out_data holds a result.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 out_data  output  OUT_W  signed quantized result.
REQ-014 busy  output  1  high while any pipeline stage holds valid data.
REQ-015 cfg_err  output  1  sticky flag, set by a config write rejected while busy.

Function
REQ-016 Transfer occurs on a rising edge with valid and ready both high, on either port.
REQ-017 Pipeline has 3 stages; advance enable = !out_valid || out_ready; in_ready = advance enable; all stages stall together when disabled.
REQ-018 S1: x = in_acc + bias (ACC_W wrap); if output_shift > 0, x = x << output_shift (ACC_W wrap).
REQ-019 S2: saturating rounding doubling high multiply of x by output_multiplier: if both equal -2^31, result 2^31-1; else p = 64-bit signed product, nudge = 2^30 if p >= 0 else 1-2^30, result = (p+nudge)/2^31 truncated toward zero.
REQ-020 S3: if output_shift < 0, e = -output_shift, mask = 2^e-1, rem = y & mask, thr = (mask>>1) + (y<0), y = (y >>> e) + (rem > thr); then y + output_offset clamped to [act_min, act_max], truncated to OUT_W.
REQ-021 Latency in_valid accept to out_valid = 3 cycles with out_ready held high; throughput one result per cycle.
REQ-022 Results emerge in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-023 out_data and out_valid stable while out_valid && !out_ready.
REQ-024 output_shift legal range -31..30; behaviour outside range unspecified.
REQ-025 cfg_we with busy low updates the addressed register next edge; with busy high the write is discarded and cfg_err set; cfg_addr 6..7 ignored.
REQ-026 cfg_we concurrent with in_valid acceptance while busy low: write applies; the accepted sample uses the new value in every stage.
REQ-027 cfg_err clears only on reset.

Reset
REQ-028 rst_n low clears all stage valid bits, out_valid=0, busy=0, cfg_err=0, out_data=0, asynchronously.
REQ-029 Reset values: bias 0, output_multiplier 0, output_shift 0, output_offset 0, act_min -128, act_max 127.
REQ-030 Reset mid-operation discards all in-flight results; first post-reset accept yields out_valid after exactly 3 cycles.

Structure
REQ-031 Package requant_pkg holds ACC_W/OUT_W defaults, cfg address constants, INT32_MIN/MAX constants.
REQ-032 Sub-module requant_srdhm implements REQ-019 as one registered stage (S2).

Verification
REQ-033 bias 0, mult 0x40000000, shift -1, offset -3; in_acc 100 -> out_data 22 at cycle 3.
REQ-034 mult 0x40000000, shift -1, offset 0; in_acc -10 -> SRDHM -5, round-away -> out_data -3.
REQ-035 mult 0x80000000, in_acc 0x80000000, bias 0 -> saturates to 2^31-1, clamps -> out_data 127.
REQ-036 5 back-to-back inputs 1..5 (mult 0x7FFFFFFF, shift 0), out_ready low cycles 4-6 -> outputs 1..5 in order, in_ready low during stall.
REQ-037 Write act_max while busy -> value unchanged, cfg_err=1; assert rst_n mid-stream -> out_valid 0, busy 0, cfg_err 0 immediately.
